// File: rtl/ysyx_22041412_axi_sram_responder_pkg.sv
`default_nettype none
// ============================================================================
// Package : ysyx_22041412_axi_pkg
// Brief   : AXI response codes, channel state encodings and beat-size helpers
//           shared by the SRAM responder and the master-side bridge.
// Rev     : 1.0  initial release
// ============================================================================
package ysyx_22041412_axi_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [0:0] {
      R_IDLE  = 1'b0,
      R_BURST = 1'b1
   } rd_state_t;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_DATA = 2'd1,
      W_RESP = 2'd2
   } wr_state_t;

   // Beats wider than the 64-bit bus are treated as full-width beats.
   function automatic logic [1:0] size_clamp(input logic [2:0] size);
      return (size > 3'd3) ? 2'd3 : size[1:0];
   endfunction

   // Byte increment between consecutive beats of an INCR burst.
   function automatic logic [3:0] beat_step(input logic [1:0] size);
      return 4'd1 << size;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_22041412_axi_sram_responder_if.sv
`default_nettype none
// ============================================================================
// Interface : ysyx_22041412_axi_sram_responder_if
// Brief     : AXI4 subset (AW/W/B/AR/R) between a master and the SRAM responder.
// Rev       : 1.0  initial release
// ============================================================================
interface ysyx_22041412_axi_sram_responder_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64
);
   logic              aw_valid;
   logic              aw_ready;
   logic [ADDR_W-1:0] aw_addr;
   logic [7:0]        aw_len;
   logic [2:0]        aw_size;
   logic              w_valid;
   logic              w_ready;
   logic [DATA_W-1:0] w_data;
   logic [DATA_W/8-1:0] w_strb;
   logic              w_last;
   logic              b_valid;
   logic              b_ready;
   logic [1:0]        b_resp;
   logic              ar_valid;
   logic              ar_ready;
   logic [ADDR_W-1:0] ar_addr;
   logic [7:0]        ar_len;
   logic [2:0]        ar_size;
   logic              r_valid;
   logic              r_ready;
   logic [DATA_W-1:0] r_data;
   logic [1:0]        r_resp;
   logic              r_last;

   modport master (
      output aw_valid, aw_addr, aw_len, aw_size, input aw_ready,
      output w_valid, w_data, w_strb, w_last, input w_ready,
      input b_valid, b_resp, output b_ready,
      output ar_valid, ar_addr, ar_len, ar_size, input ar_ready,
      input r_valid, r_data, r_resp, r_last, output r_ready
   );

   modport slave (
      input aw_valid, aw_addr, aw_len, aw_size, output aw_ready,
      input w_valid, w_data, w_strb, w_last, output w_ready,
      output b_valid, b_resp, input b_ready,
      input ar_valid, ar_addr, ar_len, ar_size, output ar_ready,
      output r_valid, r_data, r_resp, r_last, input r_ready
   );
endinterface
`default_nettype wire

// File: rtl/ysyx_22041412_axi_sram_responder_sram.sv
`default_nettype none
// ============================================================================
// Module : ysyx_22041412_sram_bytewr
// Brief  : 2^MEM_AW x 64 SRAM, one synchronous byte-enabled write port and one
//          registered read port. Reading and writing one word in the same
//          cycle returns the old contents. Array contents are not reset.
// Rev    : 1.0  initial release
// ============================================================================
module ysyx_22041412_sram_bytewr #(
   parameter int MEM_AW = 12
) (
   input  wire logic              clk,
   input  wire logic              rst,
   input  wire logic              i_we,
   input  wire logic [MEM_AW-1:0] i_waddr,
   input  wire logic [7:0]        i_wbe,
   input  wire logic [63:0]       i_wdata,
   input  wire logic              i_re,
   input  wire logic [MEM_AW-1:0] i_raddr,
   output logic      [63:0]       o_rdata
);
   logic [63:0] r_mem [0:(1<<MEM_AW)-1];
   logic [63:0] r_q;

   // Byte-lane writes; lanes without an enable keep their contents.
   always_ff @(posedge clk) begin
      if (i_we) begin
         for (int b = 0; b < 8; b++) begin
            if (i_wbe[b]) r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
         end
      end
   end

   // Read register only advances when asked, so it holds through stalls.
   always_ff @(posedge clk) begin
      if (rst)       r_q <= '0;
      else if (i_re) r_q <= r_mem[i_raddr];
   end

   assign o_rdata = r_q;
endmodule
`default_nettype wire

// File: rtl/ysyx_22041412_axi_sram_responder.sv
`default_nettype none
// ============================================================================
// Module : ysyx_22041412_axi_sram_responder
// Brief  : AXI4 slave memory model. Independent INCR read (AR->R) and write
//          (AW->W->B) engines in front of a byte-writable SRAM; accesses
//          outside the decoded window answer SLVERR.
// Rev    : 1.0  initial release
// ============================================================================
module ysyx_22041412_axi_sram_responder
   import ysyx_22041412_axi_pkg::*;
#(
   parameter int                        AXI_DATA_WIDTH = 64,
   parameter int                        AXI_ADDR_WIDTH = 32,
   parameter int                        MEM_AW         = 12,
   parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = 32'h8000_0000
) (
   input wire logic clk,
   input wire logic rst,
   ysyx_22041412_axi_sram_responder_if.slave bus
);
   localparam int c_lw  = MEM_AW + 3;
   localparam int c_aw1 = AXI_ADDR_WIDTH + 1;
   localparam logic [AXI_ADDR_WIDTH:0] c_win_end = {1'b0, BASE_ADDR} + (c_aw1'(8) << MEM_AW);

   function automatic logic in_win(input logic [AXI_ADDR_WIDTH-1:0] a);
      return ({1'b0, a} >= {1'b0, BASE_ADDR}) && ({1'b0, a} < c_win_end);
   endfunction

   // Only the in-window offset bits advance, so a burst wraps modulo depth.
   function automatic logic [AXI_ADDR_WIDTH-1:0] next_addr(input logic [AXI_ADDR_WIDTH-1:0] a,
                                                           input logic [1:0] s);
      logic [c_lw-1:0] lo;
      lo = a[c_lw-1:0] + c_lw'(beat_step(s));
      return {a[AXI_ADDR_WIDTH-1:c_lw], lo};
   endfunction

   // ---------------- read channel state ----------------
   rd_state_t                 r_rstate;
   logic [AXI_ADDR_WIDTH-1:0] r_raddr;
   logic [7:0]                r_rlen, r_rcnt;
   logic [1:0]                r_rsize;
   logic                      r_rmiss, r_rvalid, r_arready;

   // ---------------- write channel state ----------------
   wr_state_t                 r_wstate;
   logic [AXI_ADDR_WIDTH-1:0] r_waddr;
   logic [7:0]                r_wlen, r_wcnt;
   logic [1:0]                r_wsize;
   logic                      r_werr, r_awready, r_wready, r_bvalid;

   logic [AXI_DATA_WIDTH-1:0] w_rdata;
   logic [AXI_ADDR_WIDTH-1:0] w_rnext, w_wnext;
   logic                      w_ar_hs, w_r_hs, w_r_end, w_re;
   logic                      w_aw_hs, w_w_hs, w_w_end, w_whit, w_we;
   logic [MEM_AW-1:0]         w_ridx;

   assign w_ar_hs = bus.ar_valid & r_arready;
   assign w_r_hs  = r_rvalid & bus.r_ready;
   assign w_r_end = (r_rcnt == r_rlen);
   assign w_rnext = next_addr(r_raddr, r_rsize);
   // Fetch the first word at AR acceptance and each following word as a beat retires.
   assign w_re    = w_ar_hs | (w_r_hs & ~w_r_end);
   assign w_ridx  = w_ar_hs ? bus.ar_addr[MEM_AW+2:3] : w_rnext[MEM_AW+2:3];

   assign w_aw_hs = bus.aw_valid & r_awready;
   assign w_w_hs  = bus.w_valid & r_wready;
   assign w_w_end = (r_wcnt == r_wlen);
   assign w_whit  = in_win(r_waddr);
   assign w_wnext = next_addr(r_waddr, r_wsize);
   assign w_we    = w_w_hs & w_whit;

   ysyx_22041412_sram_bytewr #(.MEM_AW(MEM_AW)) u_sram (
      .clk     (clk),
      .rst     (rst),
      .i_we    (w_we),
      .i_waddr (r_waddr[MEM_AW+2:3]),
      .i_wbe   (bus.w_strb),
      .i_wdata (bus.w_data),
      .i_re    (w_re),
      .i_raddr (w_ridx),
      .o_rdata (w_rdata)
   );

   // Read burst engine: latch AR, then walk beats as the master accepts them.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rstate  <= R_IDLE;
         r_raddr   <= '0;
         r_rlen    <= '0;
         r_rcnt    <= '0;
         r_rsize   <= '0;
         r_rmiss   <= 1'b0;
         r_rvalid  <= 1'b0;
         r_arready <= 1'b1;
      end else begin
         case (r_rstate)
            R_IDLE: begin
               if (w_ar_hs) begin
                  r_raddr   <= bus.ar_addr;
                  r_rlen    <= bus.ar_len;
                  r_rsize   <= size_clamp(bus.ar_size);
                  r_rcnt    <= '0;
                  r_rmiss   <= ~in_win(bus.ar_addr);
                  r_rvalid  <= 1'b1;
                  r_arready <= 1'b0;
                  r_rstate  <= R_BURST;
               end
            end
            R_BURST: begin
               if (w_r_hs) begin
                  if (w_r_end) begin
                     r_rvalid  <= 1'b0;
                     r_arready <= 1'b1;
                     r_rstate  <= R_IDLE;
                  end else begin
                     r_rcnt  <= r_rcnt + 8'd1;
                     r_raddr <= w_rnext;
                     r_rmiss <= ~in_win(w_rnext);
                  end
               end
            end
            default: r_rstate <= R_IDLE;
         endcase
      end
   end

   // Write burst engine: AW, data beats until the counted last beat, then B.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wstate  <= W_IDLE;
         r_waddr   <= '0;
         r_wlen    <= '0;
         r_wcnt    <= '0;
         r_wsize   <= '0;
         r_werr    <= 1'b0;
         r_awready <= 1'b1;
         r_wready  <= 1'b0;
         r_bvalid  <= 1'b0;
      end else begin
         case (r_wstate)
            W_IDLE: begin
               if (w_aw_hs) begin
                  r_waddr   <= bus.aw_addr;
                  r_wlen    <= bus.aw_len;
                  r_wsize   <= size_clamp(bus.aw_size);
                  r_wcnt    <= '0;
                  r_werr    <= 1'b0;
                  r_awready <= 1'b0;
                  r_wready  <= 1'b1;
                  r_wstate  <= W_DATA;
               end
            end
            W_DATA: begin
               if (w_w_hs) begin
                  // A decode miss or a w_last that disagrees with the beat count poisons the burst.
                  if (~w_whit | (bus.w_last != w_w_end)) r_werr <= 1'b1;
                  if (w_w_end) begin
                     r_wready <= 1'b0;
                     r_bvalid <= 1'b1;
                     r_wstate <= W_RESP;
                  end else begin
                     r_wcnt  <= r_wcnt + 8'd1;
                     r_waddr <= w_wnext;
                  end
               end
            end
            W_RESP: begin
               if (bus.b_ready) begin
                  r_bvalid  <= 1'b0;
                  r_awready <= 1'b1;
                  r_wstate  <= W_IDLE;
               end
            end
            default: r_wstate <= W_IDLE;
         endcase
      end
   end

   assign bus.ar_ready = r_arready;
   assign bus.r_valid  = r_rvalid;
   assign bus.r_last   = r_rvalid & w_r_end;
   assign bus.r_data   = r_rmiss ? '0 : w_rdata;
   assign bus.r_resp   = r_rmiss ? RESP_SLVERR : RESP_OKAY;
   assign bus.aw_ready = r_awready;
   assign bus.w_ready  = r_wready;
   assign bus.b_valid  = r_bvalid;
   assign bus.b_resp   = r_werr ? RESP_SLVERR : RESP_OKAY;
endmodule
`default_nettype wire
